rv_iter_divider: RTL and testbench

Iterative radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting in the EX stage directly downstream of the divide stall controller. It takes a one-cycle start from EX and the two operands, computes one quotient bit per cycle, and returns a registered result with a one-cycle done pulse. It holds busy high until then so the stall controller can freeze IF/ID/EX.

---
 rtl/rv_iter_divider.sv | 135 +++++++++++++
 tb/tb_rv_iter_divider.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rv_iter_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, registered result, one-cycle done pulse.
module rv_iter_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [1:0]      dbg_state
);
    localparam int CW = $clog2(XLEN);

    // Handshake: start is sampled only while idle (state IDLE, busy low); the
    // accept edge latches operands, busy is high until the cycle before the
    // done pulse, and result stays valid from done until the next accept.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state;
    logic [1:0]      op_q;
    logic            neg_quo;
    logic            neg_rem;
    logic            special;
    logic [XLEN-1:0] dvs;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quo;
    logic [CW-1:0]   cnt;

    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic [XLEN:0]   shifted;
    logic            fits;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & dividend[XLEN-1];
        b_neg     = is_signed & divisor[XLEN-1];
        a_mag     = a_neg ? (~dividend + 1'b1) : dividend;
        b_mag     = b_neg ? (~divisor + 1'b1) : divisor;
        div_zero  = (divisor == '0);
        overflow  = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                    && (divisor == '1);
        shifted   = {rem[XLEN-1:0], quo[XLEN-1]};
        fits      = (shifted >= {1'b0, dvs});
        quo_fix   = neg_quo ? (~quo + 1'b1) : quo;
        rem_fix   = neg_rem ? (~rem[XLEN-1:0] + 1'b1) : rem[XLEN-1:0];
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op_q    <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            special <= 1'b0;
            dvs     <= '0;
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        neg_quo <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        dvs     <= b_mag;
                        rem     <= '0;
                        busy    <= 1'b1;
                        cnt     <= CW'(XLEN - 1);
                        // Special-case presets ride in quo and skip sign fix-up.
                        if (div_zero) begin
                            special <= 1'b1;
                            quo     <= op[1] ? dividend : '1;
                            state   <= FIX;
                        end else if (overflow) begin
                            special <= 1'b1;
                            quo     <= op[1] ? '0 : dividend;
                            state   <= FIX;
                        end else begin
                            special <= 1'b0;
                            quo     <= a_mag;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (fits) begin
                        rem <= shifted - {1'b0, dvs};
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= shifted;
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                FIX: begin
                    if (special)      result <= quo;
                    else if (op_q[1]) result <= rem_fix;
                    else              result <= quo_fix;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv_iter_divider.sv
// Directed bench for rv_iter_divider: unsigned, signed, special cases,
// ignored mid-op start, back-to-back accept and mid-op reset.
module tb_rv_iter_divider;
    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    rv_iter_divider #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .result(result), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op, scramble the operands after accept, then watch until done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int bc, output bit got,
                          output logic busy_at_done);
        @(negedge clk);
        op = o; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom; op = 2'($urandom_range(0, 3));
        bc = 0; got = 1'b0; res = 'x; busy_at_done = 1'bx;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1; res = result; busy_at_done = busy;
                break;
            end
            if (busy) bc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = '0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h exp=0", result); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        reset = 1'b1;
    endtask

    // Normal ops: busy high 33 cycles, done with busy low.
    task automatic test_vec(input string name, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int exp_bc);
        logic [31:0] res; int bc; bit got; logic bd;
        run_op(o, a, b, res, bc, got, bd);
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL %s_timeout got=%b exp=1", name, got); end
        n_cmp++; if (res !== exp) begin n_err++; $display("FAIL %s_result got=%h exp=%h", name, res, exp); end
        n_cmp++; if (bc !== exp_bc) begin n_err++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, bc, exp_bc); end
        n_cmp++; if (bd !== 1'b0) begin n_err++; $display("FAIL %s_busy_at_done got=%b exp=0", name, bd); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL %s_done_pulse got=%b exp=0", name, done); end
        n_cmp++; if (result !== exp) begin n_err++; $display("FAIL %s_held got=%h exp=%h", name, result, exp); end
    endtask

    task automatic test_unsigned();
        test_vec("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 33);
        test_vec("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 33);
        test_vec("divu_big", DIVU, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 33);
    endtask

    task automatic test_signed();
        test_vec("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        test_vec("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        test_vec("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        test_vec("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        test_vec("div_m8_m2", DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd4, 33);
    endtask

    // Special cases: one busy cycle, done on the next (latency 2 counting the accept cycle).
    task automatic test_special();
        test_vec("divu_5_0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        test_vec("rem_5_0", REM, 32'd5, 32'd0, 32'd5, 1);
        test_vec("div_m5_0", DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
        test_vec("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        test_vec("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    endtask

    // Mid-op start is ignored; start in the done cycle is accepted.
    task automatic test_back_to_back();
        bit got; int bc;
        @(negedge clk);
        op = DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        op = DIVU; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin got = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL b2b_first_timeout got=%b exp=1", got); end
        n_cmp++; if (result !== 32'd14) begin n_err++; $display("FAIL b2b_first_result got=%h exp=%h", result, 32'd14); end
        op = REMU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
        got = 1'b0; bc = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin got = 1'b1; break; end
            if (busy) bc++;
            @(negedge clk);
        end
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL b2b_second_timeout got=%b exp=1", got); end
        n_cmp++; if (result !== 32'd2) begin n_err++; $display("FAIL b2b_second_result got=%h exp=%h", result, 32'd2); end
        n_cmp++; if (bc !== 33) begin n_err++; $display("FAIL b2b_second_busy got=%0d exp=33", bc); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        op = DIVU; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
        reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_reset_done got=%b exp=0", done); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL mid_reset_result got=%h exp=0", result); end
        repeat (40) @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_reset_no_done got=%b exp=0", done); end
        reset = 1'b1;
        test_vec("after_reset", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
